// File: rtl/time_keeper.sv
// BCD time-of-day keeper: HH:MM:SS counter with digit-wise time setting,
// a seconds-since-midnight readout and minute/day rollover pulses.
module time_keeper (
    input  logic        clk_out,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [2:0]  select,
    input  logic [3:0]  loadin,
    output logic [3:0]  h1,
    output logic [3:0]  h2,
    output logic [3:0]  m1,
    output logic [3:0]  m2,
    output logic [3:0]  s1,
    output logic [3:0]  s2,
    output logic [16:0] sec_cnt,
    output logic        min_tick,
    output logic        day_wrap
);

    logic [3:0]  h1_q, h2_q, m1_q, m2_q, s1_q, s2_q;
    logic [3:0]  h1_d, h2_d, m1_d, m2_d, s1_d, s2_d;
    logic [16:0] sec_cnt_q, sec_cnt_d;
    logic        min_tick_q, min_tick_d;
    logic        day_wrap_q, day_wrap_d;

    logic        count;
    logic        sec_wrap;
    logic        hour_carry;
    logic        day_end;

    assign count      = en && !load;
    assign sec_wrap   = (s1_q == 4'd5) && (s2_q == 4'd9);
    assign hour_carry = sec_wrap && (m1_q == 4'd5) && (m2_q == 4'd9);
    assign day_end    = hour_carry && (h1_q == 4'd2) && (h2_q == 4'd3);

    // Next-state digits: either a validated digit write, a one-second advance, or hold.
    always_comb begin
        h1_d = h1_q;
        h2_d = h2_q;
        m1_d = m1_q;
        m2_d = m2_q;
        s1_d = s1_q;
        s2_d = s2_q;
        min_tick_d = 1'b0;
        day_wrap_d = 1'b0;

        if (load) begin
            // Each write is range-checked against what the digit may legally hold;
            // the h2 limit depends on the current tens-of-hours digit.
            unique case (select)
                3'b000: if (loadin <= 4'd9) s2_d = loadin;
                3'b001: if (loadin <= 4'd5) s1_d = loadin;
                3'b010: if (loadin <= 4'd9) m2_d = loadin;
                3'b011: if (loadin <= 4'd5) m1_d = loadin;
                3'b100: begin
                    if ((h1_q < 4'd2 && loadin <= 4'd9) || (h1_q == 4'd2 && loadin <= 4'd3))
                        h2_d = loadin;
                end
                3'b101: begin
                    if (loadin <= 4'd2) begin
                        h1_d = loadin;
                        // Moving into the 20s must not leave an hour like 27.
                        if (loadin == 4'd2 && h2_q > 4'd3)
                            h2_d = 4'd0;
                    end
                end
                default: ;
            endcase
        end else if (en) begin
            min_tick_d = sec_wrap;
            day_wrap_d = day_end;

            if (s2_q == 4'd9) begin
                s2_d = 4'd0;
                if (s1_q == 4'd5) begin
                    s1_d = 4'd0;
                    if (m2_q == 4'd9) begin
                        m2_d = 4'd0;
                        if (m1_q == 4'd5) begin
                            m1_d = 4'd0;
                            if (h1_q == 4'd2 && h2_q == 4'd3) begin
                                h1_d = 4'd0;
                                h2_d = 4'd0;
                            end else if (h2_q == 4'd9) begin
                                h1_d = h1_q + 4'd1;
                                h2_d = 4'd0;
                            end else begin
                                h2_d = h2_q + 4'd1;
                            end
                        end else begin
                            m1_d = m1_q + 4'd1;
                        end
                    end else begin
                        m2_d = m2_q + 4'd1;
                    end
                end else begin
                    s1_d = s1_q + 4'd1;
                end
            end else begin
                s2_d = s2_q + 4'd1;
            end
        end
    end

    // Seconds-since-midnight of the digits currently held; registered so it lags by one edge.
    always_comb begin
        sec_cnt_d = {13'd0, h1_q} * 17'd36000
                  + {13'd0, h2_q} * 17'd3600
                  + {13'd0, m1_q} * 17'd600
                  + {13'd0, m2_q} * 17'd60
                  + {13'd0, s1_q} * 17'd10
                  + {13'd0, s2_q};
    end

    // State registers; reset overrides both loading and counting.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            h1_q       <= 4'd0;
            h2_q       <= 4'd0;
            m1_q       <= 4'd0;
            m2_q       <= 4'd0;
            s1_q       <= 4'd0;
            s2_q       <= 4'd0;
            sec_cnt_q  <= 17'd0;
            min_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            h1_q       <= h1_d;
            h2_q       <= h2_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            sec_cnt_q  <= sec_cnt_d;
            min_tick_q <= min_tick_d;
            day_wrap_q <= day_wrap_d;
        end
    end

    assign h1       = h1_q;
    assign h2       = h2_q;
    assign m1       = m1_q;
    assign m2       = m2_q;
    assign s1       = s1_q;
    assign s2       = s2_q;
    assign sec_cnt  = sec_cnt_q;
    assign min_tick = min_tick_q;
    assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: counting, carries, loading rules, pulses and reset.
module tb_time_keeper;

    logic        clk_out = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [2:0]  select = 3'd0;
    logic [3:0]  loadin = 4'd0;
    logic [3:0]  h1, h2, m1, m2, s1, s2;
    logic [16:0] sec_cnt;
    logic        min_tick, day_wrap;

    int checks = 0;
    int failures = 0;

    time_keeper dut (
        .clk_out (clk_out),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .select  (select),
        .loadin  (loadin),
        .h1      (h1),
        .h2      (h2),
        .m1      (m1),
        .m2      (m2),
        .s1      (s1),
        .s2      (s2),
        .sec_cnt (sec_cnt),
        .min_tick(min_tick),
        .day_wrap(day_wrap)
    );

    always #5 clk_out = ~clk_out;

    // Packed BCD view of the time: 12:34:56 reads as 24'h123456.
    function automatic logic [23:0] now();
        return {h1, h2, m1, m2, s1, s2};
    endfunction

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic set_digit(input logic [2:0] sel, input logic [3:0] val);
        load   = 1'b1;
        select = sel;
        loadin = val;
        tick();
    endtask

    task automatic load_time(input logic [23:0] t);
        set_digit(3'b101, t[23:20]);
        set_digit(3'b100, t[19:16]);
        set_digit(3'b011, t[15:12]);
        set_digit(3'b010, t[11:8]);
        set_digit(3'b001, t[7:4]);
        set_digit(3'b000, t[3:0]);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b0;
        tick();
        tick();
        checks++;
        if (now() !== 24'h000000 || sec_cnt !== 17'd0 || min_tick !== 1'b0 || day_wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: time=%h sec=%0d mt=%b dw=%b, want 000000 0 0 0",
                     now(), sec_cnt, min_tick, day_wrap);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (now() !== 24'h000001) begin
            failures++;
            $display("FAIL first_count: time=%h want 000001", now());
        end
        $display("test_reset: time=%h sec=%0d", now(), sec_cnt);
    endtask

    task automatic test_count_61();
        int ticks;
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1;
        ticks = 0;
        for (int i = 0; i < 61; i++) begin
            tick();
            if (min_tick === 1'b1) ticks++;
        end
        checks++;
        if (now() !== 24'h000101) begin
            failures++;
            $display("FAIL count61_time: time=%h want 000101", now());
        end
        checks++;
        if (ticks != 1) begin
            failures++;
            $display("FAIL count61_min_tick: pulses=%0d want 1", ticks);
        end
        checks++;
        if (sec_cnt !== 17'd60) begin
            failures++;
            $display("FAIL count61_sec_lag: sec=%0d want 60", sec_cnt);
        end
        en = 1'b0;
        tick();
        checks++;
        if (sec_cnt !== 17'd61) begin
            failures++;
            $display("FAIL count61_sec: sec=%0d want 61", sec_cnt);
        end
        $display("test_count_61: time=%h sec=%0d pulses=%0d", now(), sec_cnt, ticks);
    endtask

    task automatic test_day_wrap();
        en = 1'b1;
        load_time(24'h235958);
        checks++;
        if (now() !== 24'h235958 || min_tick !== 1'b0) begin
            failures++;
            $display("FAIL dw_load: time=%h mt=%b want 235958 0", now(), min_tick);
        end
        tick();
        checks++;
        if (now() !== 24'h235959 || min_tick !== 1'b0 || day_wrap !== 1'b0) begin
            failures++;
            $display("FAIL dw_resume: time=%h mt=%b dw=%b want 235959 0 0", now(), min_tick, day_wrap);
        end
        tick();
        checks++;
        if (now() !== 24'h000000 || min_tick !== 1'b1 || day_wrap !== 1'b1 || sec_cnt !== 17'd86399) begin
            failures++;
            $display("FAIL dw_wrap: time=%h mt=%b dw=%b sec=%0d want 000000 1 1 86399",
                     now(), min_tick, day_wrap, sec_cnt);
        end
        en = 1'b0;
        tick();
        checks++;
        if (min_tick !== 1'b0 || day_wrap !== 1'b0 || sec_cnt !== 17'd0) begin
            failures++;
            $display("FAIL dw_after: mt=%b dw=%b sec=%0d want 0 0 0", min_tick, day_wrap, sec_cnt);
        end
        $display("test_day_wrap: time=%h sec=%0d", now(), sec_cnt);
    endtask

    task automatic test_hour_write();
        en = 1'b0;
        set_digit(3'b101, 4'd1);
        set_digit(3'b100, 4'd7);
        set_digit(3'b101, 4'd2);
        checks++;
        if (h1 !== 4'd2 || h2 !== 4'd0) begin
            failures++;
            $display("FAIL h1_clear_h2: h1=%0d h2=%0d want 2 0", h1, h2);
        end
        set_digit(3'b100, 4'd5);
        checks++;
        if (h2 !== 4'd0) begin
            failures++;
            $display("FAIL h2_limit_20s: h2=%0d want 0", h2);
        end
        set_digit(3'b100, 4'd3);
        checks++;
        if (h2 !== 4'd3) begin
            failures++;
            $display("FAIL h2_accept_3: h2=%0d want 3", h2);
        end
        set_digit(3'b101, 4'd3);
        checks++;
        if (h1 !== 4'd2) begin
            failures++;
            $display("FAIL h1_limit: h1=%0d want 2", h1);
        end
        load = 1'b0;
        $display("test_hour_write: time=%h", now());
    endtask

    task automatic test_illegal_writes();
        en = 1'b1;
        load_time(24'h124321);
        set_digit(3'b011, 4'd6);
        set_digit(3'b110, 4'd3);
        set_digit(3'b111, 4'd1);
        set_digit(3'b001, 4'd6);
        set_digit(3'b000, 4'd10);
        checks++;
        if (now() !== 24'h124321) begin
            failures++;
            $display("FAIL illegal_ignored: time=%h want 124321", now());
        end
        set_digit(3'b001, 4'd5);
        set_digit(3'b000, 4'd9);
        set_digit(3'b000, 4'd9);
        checks++;
        if (now() !== 24'h124359 || min_tick !== 1'b0) begin
            failures++;
            $display("FAIL legal_limits: time=%h mt=%b want 124359 0", now(), min_tick);
        end
        load = 1'b0;
        $display("test_illegal_writes: time=%h", now());
    endtask

    task automatic test_hold();
        int pulses;
        en = 1'b0;
        load_time(24'h123450);
        en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (now() !== 24'h123456) begin
            failures++;
            $display("FAIL hold_reach: time=%h want 123456", now());
        end
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (min_tick !== 1'b0 || day_wrap !== 1'b0) pulses++;
        end
        checks++;
        if (now() !== 24'h123456 || sec_cnt !== 17'd45296 || pulses != 0) begin
            failures++;
            $display("FAIL hold_frozen: time=%h sec=%0d pulses=%0d want 123456 45296 0",
                     now(), sec_cnt, pulses);
        end
        $display("test_hold: time=%h sec=%0d", now(), sec_cnt);
    endtask

    task automatic test_back_to_back();
        en = 1'b1;
        load_time(24'h095959);
        tick();
        checks++;
        if (now() !== 24'h100000 || min_tick !== 1'b1 || day_wrap !== 1'b0) begin
            failures++;
            $display("FAIL roll_09_10: time=%h mt=%b dw=%b want 100000 1 0", now(), min_tick, day_wrap);
        end
        load_time(24'h195959);
        checks++;
        if (min_tick !== 1'b0) begin
            failures++;
            $display("FAIL load_no_tick: mt=%b want 0", min_tick);
        end
        tick();
        checks++;
        if (now() !== 24'h200000) begin
            failures++;
            $display("FAIL roll_19_20: time=%h want 200000", now());
        end
        $display("test_back_to_back: time=%h", now());
    endtask

    task automatic test_reset_priority();
        en = 1'b1;
        load_time(24'h095959);
        rst = 1'b1;
        tick();
        checks++;
        if (now() !== 24'h000000 || min_tick !== 1'b0 || day_wrap !== 1'b0 || sec_cnt !== 17'd0) begin
            failures++;
            $display("FAIL rst_mid_carry: time=%h mt=%b dw=%b sec=%0d want 000000 0 0 0",
                     now(), min_tick, day_wrap, sec_cnt);
        end
        set_digit(3'b000, 4'd5);
        checks++;
        if (s2 !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid_load: s2=%0d want 0", s2);
        end
        load = 1'b0;
        rst  = 1'b0;
        tick();
        checks++;
        if (now() !== 24'h000001) begin
            failures++;
            $display("FAIL rst_resume: time=%h want 000001", now());
        end
        $display("test_reset_priority: time=%h", now());
    endtask

    initial begin
        test_reset();
        test_count_61();
        test_day_wrap();
        test_hour_write();
        test_illegal_writes();
        test_hold();
        test_back_to_back();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have ports, clock and reset first:
  clk_out  in   1   sole clock; one rising edge = one second while counting
  rst      in   1   synchronous, active-high reset
  en       in   1   count enable; time advances only when 1
  load     in   1   1 = time-set mode: counting frozen, digit writes accepted
  select   in   3   digit to write: 000 s2, 001 s1, 010 m2, 011 m1, 100 h2, 101 h1; 110/111 ignored
  loadin   in   4   BCD value for the selected digit
  h1,h2    out  4   hours tens/units, BCD, registered
  m1,m2    out  4   minutes tens/units, BCD, registered
  s1,s2    out  4   seconds tens/units, BCD, registered
  sec_cnt  out  17  seconds since midnight, 0..86399, registered
  min_tick out  1   one-cycle pulse on each minute rollover while counting
  day_wrap out  1   one-cycle pulse on the 23:59:59 -> 00:00:00 transition
REQ-002 SHALL use no clock other than clk_out, and no asynchronous logic.

Function
REQ-003 Count mode (load=0, en=1): each edge SHALL advance time by exactly one second.
REQ-004 Carry chain: s2 9->0 carries to s1; s1 5->0 carries to m2; m2 9->0 to m1; m1 5->0 to hours.
REQ-005 Hours SHALL advance 09->10, 19->20, and 23->00; no other hour roll.
REQ-006 load=0, en=0: all digits and sec_cnt SHALL hold; no pulses.
REQ-007 load=1: counting SHALL freeze regardless of en; only the selected digit may change.
REQ-008 Write acceptance limits: s2<=9, s1<=5, m2<=9, m1<=5, h1<=2; h2<=9 when h1<2, h2<=3 when h1=2.
REQ-009 Out-of-range writes, and writes with select 110/111, SHALL be ignored; the digit holds.
REQ-010 Accepted h1=2 write while h2>3 SHALL also clear h2 to 0 in the same edge.
REQ-011 Digit writes SHALL take effect on the edge at which load=1; re-writing the same value is harmless.
REQ-012 sec_cnt SHALL equal h1*36000+h2*3600+m1*600+m2*60+s1*10+s2 of the digits held one edge earlier (1-cycle latency).
REQ-013 sec_cnt arithmetic SHALL be 17 bits wide with no truncation; max 86399.
REQ-014 min_tick SHALL be 1 for the single cycle following the edge where s1:s2 went 59->00 by counting; never asserted by a load.
REQ-015 day_wrap SHALL be 1 for the single cycle following the 23:59:59->00:00:00 counting edge; min_tick is also 1 in that cycle.
REQ-016 load falling 1->0 SHALL resume counting from the loaded value on the next edge with en=1; no second is skipped or doubled.
REQ-017 Digits SHALL never hold an illegal BCD or time value reachable from reset.

Reset
REQ-018 rst=1 at an edge SHALL set all digits to 0, sec_cnt to 0, min_tick and day_wrap to 0.
REQ-019 rst SHALL take priority over load and en, including mid-load and mid-carry.
REQ-020 The first counting edge after rst deasserts SHALL produce 00:00:01.

Verification
REQ-021 Reset, then 61 edges with en=1 -> 00:01:01; min_tick high exactly once; sec_cnt=61 one edge later.
REQ-022 Load 23:59:58, then 2 counting edges -> 00:00:00; day_wrap and min_tick pulse once; sec_cnt reads 86399 then 0.
REQ-023 load=1, select=101, loadin=2 while h2=7 -> h1=2, h2=0; then select=100, loadin=5 -> ignored, h2=0.
REQ-024 load=1, select=011, loadin=6 -> m1 unchanged; select=110, loadin=3 -> no digit changes.
REQ-025 Count to 12:34:56, assert en=0 for 10 edges -> time holds 12:34:56, sec_cnt=45296, no pulses.
REQ-026 rst asserted at 09:59:59 in the same edge as a count -> 00:00:00, no min_tick or day_wrap.
